// File: rtl/lcd_frame_capture.sv
// ---------------------------------------------------------------------------
// lcd_frame_capture
//
// Captures the DMG LCD pixel stream (2 bits per pixel) into a double-buffered
// WIDTH x HEIGHT framebuffer. The stream is written into the back bank. A
// complete frame is presented to readers by toggling front_bank on vsync.
// Malformed lines and frames raise sticky error flags.
//
// Ports:
//   clk          system clock (same clock as the DMG core)
//   rst          synchronous, active-low reset
//   lcd_pixel    strobe: lcd_color is the next pixel in raster order
//   lcd_color    pixel shade, 0 = lightest
//   lcd_hsync    strobe: end of the current line
//   lcd_vsync    strobe: end of the frame (entry to vblank)
//   rd_en        read request, samples rd_x / rd_y
//   rd_x, rd_y   read column / row
//   rd_data      shade read from the front bank
//   rd_valid     rd_data is valid
//   front_bank   bank currently presented to readers
//   frame_ready  one-cycle pulse on each bank swap
//   frame_cnt    completed frames, wraps modulo 256
//   err_overflow sticky: pixel beyond WIDTH or HEIGHT was dropped
//   err_line     sticky: line ended with a pixel count other than WIDTH
//   err_frame    sticky: vsync with a line count other than HEIGHT
//   clr_err      clears all sticky error flags (wins over a same-cycle set)
//
// Read handshake: there is no back-pressure. A read is accepted in every cycle
// in which rd_en is high. Exactly one cycle later rd_valid is high for one
// cycle, and rd_data holds the result. Out-of-range coordinates return 0 with
// rd_valid still high. Reads may be issued every cycle.
// ---------------------------------------------------------------------------
module lcd_frame_capture #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_pixel,
  input  logic [1:0] lcd_color,
  input  logic       lcd_hsync,
  input  logic       lcd_vsync,
  input  logic       rd_en,
  input  logic [7:0] rd_x,
  input  logic [7:0] rd_y,
  output logic [1:0] rd_data,
  output logic       rd_valid,
  output logic       front_bank,
  output logic       frame_ready,
  output logic [7:0] frame_cnt,
  output logic       err_overflow,
  output logic       err_line,
  output logic       err_frame,
  input  logic       clr_err
);

  localparam int DEPTH = WIDTH * HEIGHT;
  // row_base may reach DEPTH after the last hsync of a frame, so size for it
  localparam int AW = $clog2(DEPTH + 1);
  localparam logic [7:0]    W8 = 8'(WIDTH);
  localparam logic [7:0]    H8 = 8'(HEIGHT);
  localparam logic [AW-1:0] WA = AW'(WIDTH);

  // Frame storage; contents are intentionally not reset
  logic [1:0] r_mem0 [0:DEPTH-1];
  logic [1:0] r_mem1 [0:DEPTH-1];

  // Write-side position
  logic [7:0]    r_wr_x;
  logic [7:0]    r_wr_y;
  logic [AW-1:0] r_row_base;

  // Presentation state and flags
  logic       r_front;
  logic       r_ready;
  logic [7:0] r_cnt;
  logic       r_err_ov;
  logic       r_err_line;
  logic       r_err_frame;

  // Read pipeline
  logic [1:0] r_rd_data;
  logic       r_rd_valid;

  logic          w_pix_ok;
  logic [AW-1:0] w_wr_addr;
  logic [7:0]    w_x_after;
  logic          w_line_adv;
  logic [7:0]    w_y_after;
  logic          w_swap;
  logic          w_set_ov;
  logic          w_set_line;
  logic          w_set_frame;
  logic          w_rd_in_range;
  logic [AW-1:0] w_rd_addr;

  // Same-cycle strobes resolve in the order pixel -> hsync -> vsync, so each
  // stage looks at the position produced by the stage before it.
  always_comb begin
    w_pix_ok    = lcd_pixel && (r_wr_x < W8) && (r_wr_y < H8);
    w_wr_addr   = r_row_base + AW'(r_wr_x);
    w_x_after   = w_pix_ok ? (r_wr_x + 8'd1) : r_wr_x;
    w_line_adv  = lcd_hsync && (r_wr_y < H8);
    w_y_after   = w_line_adv ? (r_wr_y + 8'd1) : r_wr_y;
    w_swap      = lcd_vsync && (w_y_after == H8);
    w_set_ov    = lcd_pixel && !w_pix_ok;
    w_set_line  = lcd_hsync && (w_x_after != W8);
    w_set_frame = lcd_vsync && (w_y_after != H8);
  end

  // Constant multiply; for WIDTH=160 this reduces to (y<<7)+(y<<5)
  always_comb begin
    w_rd_in_range = (rd_x < W8) && (rd_y < H8);
    w_rd_addr     = (AW'(rd_y) * WA) + AW'(rd_x);
  end

  // Back bank is the one not being presented
  always_ff @(posedge clk) begin
    if (rst && w_pix_ok && r_front) begin
      r_mem0[w_wr_addr] <= lcd_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_pix_ok && !r_front) begin
      r_mem1[w_wr_addr] <= lcd_color;
    end
  end

  // Write position: vsync restarts the frame, hsync restarts the line
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_x     <= 8'd0;
      r_wr_y     <= 8'd0;
      r_row_base <= '0;
    end else if (lcd_vsync) begin
      r_wr_x     <= 8'd0;
      r_wr_y     <= 8'd0;
      r_row_base <= '0;
    end else if (lcd_hsync) begin
      r_wr_x <= 8'd0;
      if (w_line_adv) begin
        r_wr_y     <= w_y_after;
        r_row_base <= r_row_base + WA;
      end
    end else begin
      r_wr_x <= w_x_after;
    end
  end

  // Bank swap, frame counter and sticky errors
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_front     <= 1'b0;
      r_ready     <= 1'b0;
      r_cnt       <= 8'd0;
      r_err_ov    <= 1'b0;
      r_err_line  <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      r_ready <= w_swap;
      if (w_swap) begin
        r_front <= ~r_front;
        r_cnt   <= r_cnt + 8'd1;
      end
      if (clr_err) begin
        r_err_ov    <= 1'b0;
        r_err_line  <= 1'b0;
        r_err_frame <= 1'b0;
      end else begin
        r_err_ov    <= r_err_ov    | w_set_ov;
        r_err_line  <= r_err_line  | w_set_line;
        r_err_frame <= r_err_frame | w_set_frame;
      end
    end
  end

  // Read port: samples the pre-swap front bank when a swap happens this cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data  <= 2'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        if (!w_rd_in_range) begin
          r_rd_data <= 2'd0;
        end else if (r_front) begin
          r_rd_data <= r_mem1[w_rd_addr];
        end else begin
          r_rd_data <= r_mem0[w_rd_addr];
        end
      end
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign front_bank   = r_front;
  assign frame_ready  = r_ready;
  assign frame_cnt    = r_cnt;
  assign err_overflow = r_err_ov;
  assign err_line     = r_err_line;
  assign err_frame    = r_err_frame;

endmodule

// File: tb/tb_lcd_frame_capture.sv
// ---------------------------------------------------------------------------
// Bench for lcd_frame_capture. The reference model keeps both banks as plain
// integer arrays (-1 = never written) and follows the raster rules directly.
// ---------------------------------------------------------------------------
module tb_lcd_frame_capture;

  localparam int W = 160;
  localparam int H = 144;
  localparam int N = W * H;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       lcd_pixel = 1'b0;
  logic [1:0] lcd_color = 2'd0;
  logic       lcd_hsync = 1'b0;
  logic       lcd_vsync = 1'b0;
  logic       rd_en     = 1'b0;
  logic [7:0] rd_x      = 8'd0;
  logic [7:0] rd_y      = 8'd0;
  logic       clr_err   = 1'b0;
  logic [1:0] rd_data;
  logic       rd_valid;
  logic       front_bank;
  logic       frame_ready;
  logic [7:0] frame_cnt;
  logic       err_overflow;
  logic       err_line;
  logic       err_frame;

  lcd_frame_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .lcd_pixel(lcd_pixel), .lcd_color(lcd_color),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .front_bank(front_bank), .frame_ready(frame_ready), .frame_cnt(frame_cnt),
    .err_overflow(err_overflow), .err_line(err_line), .err_frame(err_frame),
    .clr_err(clr_err)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model
  int         m_mem [2][N];
  bit         m_front, m_ready, m_eo, m_el, m_ef, m_rd_exp;
  int         m_cnt, m_x, m_y;
  bit         chk_next;
  logic [1:0] last_rd;
  logic [2:0] exp_q[$];   // {known, shade} per outstanding read

  // ---------------- driver ----------------
  // One clock cycle: drive at negedge, update the model at posedge, sample #1 later.
  task automatic tick(input bit pix, input logic [1:0] col, input bit hs, input bit vs,
                      input bit re, input logic [7:0] rx, input logic [7:0] ry,
                      input bit clr, input bit rst_n);
    bit         drop, so, sl, sf, do_chk;
    int         v;
    logic [2:0] e;
    @(negedge clk);
    rst = rst_n; lcd_pixel = pix; lcd_color = col; lcd_hsync = hs; lcd_vsync = vs;
    rd_en = re; rd_x = rx; rd_y = ry; clr_err = clr;
    @(posedge clk);
    drop = 0; so = 0; sl = 0; sf = 0;
    if (!rst_n) begin
      m_front = 0; m_cnt = 0; m_x = 0; m_y = 0; m_ready = 0;
      m_eo = 0; m_el = 0; m_ef = 0; m_rd_exp = 0;
    end else begin
      m_rd_exp = re;
      if (re) begin
        if (int'(rx) >= W || int'(ry) >= H) exp_q.push_back(3'b100);
        else begin
          v = m_mem[m_front][int'(ry) * W + int'(rx)];
          exp_q.push_back(v < 0 ? 3'b000 : {1'b1, 2'(v)});
        end
      end
      if (pix) begin
        if (m_x < W && m_y < H) begin
          m_mem[!m_front][m_y * W + m_x] = int'(col);
          m_x++;
        end else begin
          so = 1; drop = 1;
        end
      end
      if (hs) begin
        if (m_x != W) sl = 1;
        m_x = 0;
        if (m_y < H) m_y++;
      end
      m_ready = 0;
      if (vs) begin
        if (m_y == H) begin
          m_front = !m_front; m_ready = 1; m_cnt = (m_cnt + 1) % 256;
        end else sf = 1;
        m_x = 0; m_y = 0;
      end
      if (clr) begin
        m_eo = 0; m_el = 0; m_ef = 0;
      end else begin
        m_eo |= so; m_el |= sl; m_ef |= sf;
      end
    end
    #1;
    do_chk = hs || vs || clr || drop || re || !rst_n || chk_next;
    chk_next = vs || !rst_n;
    if (do_chk) begin
      check_eq("status", {20'd0, front_bank, frame_ready, frame_cnt, err_overflow, err_line, err_frame},
               {20'd0, m_front, m_ready, 8'(m_cnt), m_eo, m_el, m_ef});
      check_eq("rd_valid", {31'd0, rd_valid}, {31'd0, m_rd_exp});
    end
    if (!rst_n) check_eq("rst_rd_data", {30'd0, rd_data}, 32'd0);
    if (m_rd_exp && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_rd = rd_data;
      if (e[2]) check_eq("rd_data", {30'd0, rd_data}, {30'd0, e[1:0]});
    end
  endtask

  task automatic idle(input bit clr);
    tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, clr, 1'b1);
  endtask

  task automatic do_reset();
    tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic strobe(input bit hs, input bit vs);
    tick(1'b0, 2'd0, hs, vs, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic rd(input int x, input int y);
    tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'(x), 8'(y), 1'b0, 1'b1);
  endtask

  // Sends npix pixels of row y; rnd picks random shades, else (x+y)&3.
  // hs_last puts hsync on the last pixel, sep_hs adds a standalone hsync.
  // Random reads of the front bank are interleaved.
  task automatic send_line(input int npix, input int y, input bit rnd,
                           input bit hs_last, input bit sep_hs);
    for (int x = 0; x < npix; x++) begin
      logic [1:0] c;
      bit         last, re;
      c    = rnd ? 2'($urandom_range(0, 3)) : 2'((x + y) & 3);
      last = (x == npix - 1);
      re   = ($urandom_range(0, 7) == 0);
      tick(1'b1, c, last && hs_last, 1'b0, re, 8'($urandom_range(0, 169)),
           8'($urandom_range(0, 153)), 1'b0, 1'b1);
    end
    if (sep_hs) strobe(1'b1, 1'b0);
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++) rd($urandom_range(0, 169), $urandom_range(0, 153));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < N; a++) m_mem[b][a] = -1;
    chk_next = 0;
    last_rd  = 2'd0;

    repeat (3) do_reset();
    idle(1'b0);

    // Set a few flags, then abandon a 50-line partial frame with reset
    strobe(1'b0, 1'b1);             // vsync with no lines -> err_frame
    strobe(1'b1, 1'b0);             // empty line -> err_line
    strobe(1'b0, 1'b1);
    for (int y = 0; y < 50; y++) send_line(W, y, 1'b1, 1'b1, 1'b0);
    rd(3, 3);
    do_reset();
    check_eq("rst_front", {31'd0, front_bank}, 32'd0);
    check_eq("rst_cnt", {24'd0, frame_cnt}, 32'd0);
    check_eq("rst_errs", {29'd0, err_overflow, err_line, err_frame}, 32'd0);
    check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    idle(1'b0);

    // Full frame of (x+y)&3 after reset
    for (int y = 0; y < H; y++) send_line(W, y, 1'b0, 1'b1, 1'b0);
    strobe(1'b0, 1'b1);
    check_eq("full_ready", {31'd0, frame_ready}, 32'd1);
    check_eq("full_front", {31'd0, front_bank}, 32'd1);
    check_eq("full_cnt", {24'd0, frame_cnt}, 32'd1);
    check_eq("full_errs", {29'd0, err_overflow, err_line, err_frame}, 32'd0);
    idle(1'b0);
    check_eq("ready_pulse", {31'd0, frame_ready}, 32'd0);
    rd(0, 0);     check_eq("rd_0_0", {30'd0, last_rd}, 32'd0);
    rd(159, 143); check_eq("rd_159_143", {30'd0, last_rd}, 32'd2);
    rd(5, 7);     check_eq("rd_5_7", {30'd0, last_rd}, 32'd0);
    rd(200, 10);
    check_eq("oor_data", {30'd0, rd_data}, 32'd0);
    check_eq("oor_valid", {31'd0, rd_valid}, 32'd1);
    random_reads(40);

    // Short frame of 100 lines: discarded, no swap
    for (int y = 0; y < 100; y++) send_line(W, y, 1'b1, 1'b1, 1'b0);
    strobe(1'b0, 1'b1);
    check_eq("short_err_frame", {31'd0, err_frame}, 32'd1);
    check_eq("short_front", {31'd0, front_bank}, 32'd1);
    check_eq("short_cnt", {24'd0, frame_cnt}, 32'd1);
    idle(1'b1);

    // Frame with an overflowing line 0, a short line 3 and a final
    // pixel+hsync+vsync cycle that also reads (159,143)
    send_line(W + 1, 0, 1'b1, 1'b0, 1'b1);
    check_eq("ovf_flag", {31'd0, err_overflow}, 32'd1);
    for (int y = 1; y < 3; y++) send_line(W, y, 1'b1, 1'b1, 1'b0);
    send_line(150, 3, 1'b1, 1'b1, 1'b0);
    check_eq("short_line_flag", {31'd0, err_line}, 32'd1);
    for (int y = 4; y < H - 1; y++) send_line(W, y, 1'b1, 1'b1, 1'b0);
    send_line(W - 1, H - 1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b1, 8'd159, 8'd143, 1'b0, 1'b1);
    check_eq("simul_old_bank", {30'd0, last_rd}, 32'd2);
    check_eq("simul_ready", {31'd0, frame_ready}, 32'd1);
    check_eq("simul_front", {31'd0, front_bank}, 32'd0);
    check_eq("simul_cnt", {24'd0, frame_cnt}, 32'd2);
    check_eq("simul_errs", {29'd0, err_overflow, err_line, err_frame}, 32'b110);
    rd(159, 143);
    rd(0, 1);
    for (int x = 148; x < W; x++) rd(x, 3);
    random_reads(60);
    idle(1'b1);
    check_eq("clr_errs", {29'd0, err_overflow, err_line, err_frame}, 32'd0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
